// File: rtl/rv32i_alu.sv
// RV32I integer ALU: combinational result/zero for the single-cycle datapath,
// plus a registered copy (result_q/zero_q) for trace and pipelined reuse.
module rv32i_alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic [XLEN-1:0] result_q,
    output logic            zero_q
);

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_AND   = 4'b0010,
        OP_OR    = 4'b0011,
        OP_XOR   = 4'b0100,
        OP_SLL   = 4'b0101,
        OP_SRL   = 4'b0110,
        OP_SRA   = 4'b0111,
        OP_SLT   = 4'b1000,
        OP_SLTU  = 4'b1001,
        OP_PASSB = 4'b1010
    } alu_op_e;

    logic [4:0] shamt;
    logic       lt_signed;
    logic       lt_unsigned;

    assign shamt       = b[4:0];
    assign lt_signed   = $signed(a) < $signed(b);
    assign lt_unsigned = a < b;

    // Reserved encodings fall into the default arm and yield a defined zero.
    always_comb begin
        result = '0;
        case (alu_op_e'(alu_ctrl))
            OP_ADD:   result = a + b;
            OP_SUB:   result = a - b;
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
            OP_SLL:   result = a << shamt;
            OP_SRL:   result = a >> shamt;
            OP_SRA:   result = $signed(a) >>> shamt;
            OP_SLT:   result = {{(XLEN-1){1'b0}}, lt_signed};
            OP_SLTU:  result = {{(XLEN-1){1'b0}}, lt_unsigned};
            OP_PASSB: result = b;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result;
            zero_q   <= zero;
        end
    end

endmodule

// File: tb/tb_rv32i_alu.sv
// Self-checking bench for rv32i_alu: spec vectors, randomized ops against a
// behavioural model, and reset/capture behaviour of the registered outputs.
module tb_rv32i_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_ctrl;
    logic [31:0] result;
    logic        zero;
    logic [31:0] result_q;
    logic        zero_q;

    int checks   = 0;
    int failures = 0;

    rv32i_alu dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .alu_ctrl (alu_ctrl),
        .result   (result),
        .zero     (zero),
        .result_q (result_q),
        .zero_q   (zero_q)
    );

    always #5 clk = ~clk;

    // Reference model written from the opcode table using plain arithmetic.
    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic [3:0] op);
        int unsigned sh;
        logic [31:0] ones;
        logic [31:0] fill;
        sh   = y % 32;
        ones = 32'hFFFF_FFFF;
        fill = x[31] ? ~(ones >> sh) : 32'h0;
        case (op)
            4'd0:    return x + y;
            4'd1:    return x - y;
            4'd2:    return x & y;
            4'd3:    return x | y;
            4'd4:    return x ^ y;
            4'd5:    return x << sh;
            4'd6:    return x >> sh;
            4'd7:    return (x >> sh) | fill;
            4'd8:    return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
            4'd9:    return (x < y) ? 32'd1 : 32'd0;
            4'd10:   return y;
            default: return 32'h0;
        endcase
    endfunction

    task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
        a        = x;
        b        = y;
        alu_ctrl = op;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(32'd10, 32'd5, 4'd0);
        @(posedge clk);
        #1;
        checks++;
        if (result_q !== 32'h0 || zero_q !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_state: got result_q=%h zero_q=%b, want 00000000/1",
                     result_q, zero_q);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (result_q !== 32'd15 || zero_q !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_release_add: got result_q=%h zero_q=%b, want 0000000f/0",
                     result_q, zero_q);
        end
    endtask

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [3:0]  op;
        logic [31:0] exp;
    } vec_t;

    task automatic test_directed();
        vec_t vecs[$];
        logic exp_zero;
        vecs.push_back('{32'd10,         32'd5,          4'd0,  32'd15});
        vecs.push_back('{32'd10,         32'd5,          4'd1,  32'd5});
        vecs.push_back('{32'd5,          32'd5,          4'd1,  32'd0});
        vecs.push_back('{32'h0000_000A,  32'd3,          4'd5,  32'h0000_0050});
        vecs.push_back('{32'h0000_0010,  32'd2,          4'd6,  32'h0000_0004});
        vecs.push_back('{32'h8000_0000,  32'h21,         4'd6,  32'h4000_0000});
        vecs.push_back('{32'hFFFF_FFFF,  32'd1,          4'd7,  32'hFFFF_FFFF});
        vecs.push_back('{32'h8000_0000,  32'd4,          4'd7,  32'hF800_0000});
        vecs.push_back('{32'd3,          32'd7,          4'd8,  32'd1});
        vecs.push_back('{32'hFFFF_FFFF,  32'd1,          4'd8,  32'd1});
        vecs.push_back('{32'hFFFF_FFFF,  32'd1,          4'd9,  32'd0});
        vecs.push_back('{32'hF0F0_F0F0,  32'h0FF0_0FF0,  4'd2,  32'h00F0_00F0});
        vecs.push_back('{32'hF0F0_F0F0,  32'h0FF0_0FF0,  4'd3,  32'hFFF0_FFF0});
        vecs.push_back('{32'hF0F0_F0F0,  32'h0FF0_0FF0,  4'd4,  32'hFF00_FF00});
        vecs.push_back('{32'hF0F0_F0F0,  32'h0FF0_0FF0,  4'd10, 32'h0FF0_0FF0});
        vecs.push_back('{32'hF0F0_F0F0,  32'h0FF0_0FF0,  4'd15, 32'h0});
        vecs.push_back('{32'h7FFF_FFFF,  32'd1,          4'd0,  32'h8000_0000});
        vecs.push_back('{32'h1234_5678,  32'h20,         4'd5,  32'h1234_5678});
        vecs.push_back('{32'h8765_4321,  32'hFFFF_FFE0,  4'd7,  32'h8765_4321});
        vecs.push_back('{32'hDEAD_BEEF,  32'h1,          4'd11, 32'h0});
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].x, vecs[i].y, vecs[i].op);
            #1;
            exp_zero = (vecs[i].exp == 32'h0);
            checks++;
            if (result !== vecs[i].exp || zero !== exp_zero) begin
                failures++;
                $display("[TB] FAIL directed_%0d op=%h: got result=%h zero=%b, want %h/%b",
                         i, vecs[i].op, result, zero, vecs[i].exp, exp_zero);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] x;
        logic [31:0] y;
        logic [3:0]  op;
        logic [31:0] exp;
        for (int i = 0; i < 300; i++) begin
            x  = $urandom;
            y  = $urandom;
            op = 4'($urandom_range(0, 15));
            if ((i % 7) == 0) y = x;
            if ((i % 5) == 0) y = y & 32'h3F;
            @(negedge clk);
            drive(x, y, op);
            exp = model(x, y, op);
            #1;
            checks++;
            if (result !== exp || zero !== (exp == 32'h0)) begin
                failures++;
                $display("[TB] FAIL random_comb op=%h a=%h b=%h: got %h/%b, want %h/%b",
                         op, x, y, result, zero, exp, (exp == 32'h0));
            end
            @(posedge clk);
            #1;
            checks++;
            if (result_q !== exp || zero_q !== (exp == 32'h0)) begin
                failures++;
                $display("[TB] FAIL random_reg op=%h: got %h/%b, want %h/%b",
                         op, result_q, zero_q, exp, (exp == 32'h0));
            end
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        drive(32'h0000_1000, 32'h0000_0234, 4'd0);
        @(posedge clk);
        #1;
        checks++;
        if (result_q !== 32'h0000_1234) begin
            failures++;
            $display("[TB] FAIL mid_capture: got %h, want 00001234", result_q);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(32'hAAAA_0000, 32'h0000_5555, 4'd3);
        #1;
        checks++;
        if (result !== 32'hAAAA_5555 || zero !== 1'b0) begin
            failures++;
            $display("[TB] FAIL comb_under_reset: got %h/%b, want aaaa5555/0", result, zero);
        end
        @(posedge clk);
        #1;
        checks++;
        if (result_q !== 32'h0 || zero_q !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_reset_override: got %h/%b, want 00000000/1", result_q, zero_q);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (result_q !== 32'hAAAA_5555 || zero_q !== 1'b0) begin
            failures++;
            $display("[TB] FAIL post_reset_capture: got %h/%b, want aaaa5555/0", result_q, zero_q);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] prev_exp;
        prev_exp = 32'h0;
        for (int i = 0; i < 20; i++) begin
            x = $urandom;
            y = $urandom;
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (result_q !== prev_exp) begin
                    failures++;
                    $display("[TB] FAIL back_to_back_%0d: got %h, want %h", i, result_q, prev_exp);
                end
            end
            drive(x, y, 4'(i % 11));
            prev_exp = model(x, y, 4'(i % 11));
            @(posedge clk);
        end
    endtask

    initial begin
        rst = 1'b0;
        drive(32'h0, 32'h0, 4'd0);
        test_reset();
        test_directed();
        test_random();
        test_reset_midstream();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
